lsu_split: RTL and testbench

- Load/store unit between the RV32I execute stage and the 256-word data RAM.
- Turns a byte-addressed load/store into RAM accesses: word address, 4-bit byte mask and lane-aligned write data.
- Extracts and sign/zero-extends load data from the RAM's combinational read port.
- A misaligned access is split into two consecutive word accesses by a small FSM.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 38 +++
 rtl/lsu_split.sv | 160 ++++++++++++++++
 tb/tb_lsu_split.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SECOND = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Access size in bytes; illegal codes fall through to 4 and are flagged elsewhere.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] funct3, input logic we);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return ~we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store byte enables / data shift, load shift and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata64,
  output logic [7:0]  be8,
  output logic [63:0] wd64,
  output logic [31:0] load_data
);

  logic [4:0]  sh_amt;
  logic [7:0]  be_base;
  logic [63:0] rd_sh;
  logic [31:0] unused_rd_hi;

  assign sh_amt       = {off, 3'b000};
  assign be_base      = (8'd1 << size) - 8'd1;
  assign be8          = be_base << off;
  assign wd64         = {32'b0, wdata} << sh_amt;
  assign rd_sh        = rdata64 >> sh_amt;
  assign unused_rd_hi = rd_sh[63:32];

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
      F3_H:    load_data = {{16{rd_sh[15]}}, rd_sh[15:0]};
      F3_W:    load_data = rd_sh[31:0];
      F3_BU:   load_data = {24'b0, rd_sh[7:0]};
      F3_HU:   load_data = {16'b0, rd_sh[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_split.sv
// RV32I load/store unit: splits misaligned accesses into two word accesses.
// Optional MISALIGN_TRAP_EN: misaligned accesses return an error instead of splitting.
module lsu_split
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_masking,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic [1:0]        state_dbg
);

  // Handshake: a request transfers on a clk edge where req_valid and req_ready are both
  // high; req_ready is high only in IDLE. rsp_valid is a one-cycle pulse, never stalled.
  lsu_state_e        state;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [2:0]        size_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       lo_q;

  logic        accept, legal, split_raw, go_split, err, wen_ok, in_second;
  logic [1:0]  off;
  logic [2:0]  size;
  logic [1:0]  a_off;
  logic [2:0]  a_size, a_funct3;
  logic [31:0] a_wdata;
  logic [63:0] a_rdata64;
  logic [7:0]  be8;
  logic [63:0] wd64;
  logic [31:0] load_data;
  logic        unused_addr_hi;

  assign req_ready      = (state == IDLE);
  assign accept         = req_valid & req_ready;
  assign off            = req_addr[1:0];
  assign size           = size_bytes(req_funct3);
  assign legal          = f3_legal(req_funct3, req_we);
  assign split_raw      = ({2'b00, off} + {1'b0, size}) > 4'd4;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign state_dbg      = state;

`ifdef MISALIGN_TRAP_EN
  assign err      = ~legal | split_raw;
  assign go_split = 1'b0;
`else
  assign err      = ~legal;
  assign go_split = split_raw & legal;
`endif
  assign wen_ok = req_we & ~err;

  // The aligner sees the live request in IDLE and the latched one in SECOND.
  assign in_second = (state == SECOND);
  assign a_off     = in_second ? off_q    : off;
  assign a_size    = in_second ? size_q   : size;
  assign a_funct3  = in_second ? funct3_q : req_funct3;
  assign a_wdata   = in_second ? wdata_q  : req_wdata;
  assign a_rdata64 = in_second ? {mem_read_data, lo_q} : {32'b0, mem_read_data};

  lsu_align u_align (
    .off       (a_off),
    .size      (a_size),
    .funct3    (a_funct3),
    .wdata     (a_wdata),
    .rdata64   (a_rdata64),
    .be8       (be8),
    .wd64      (wd64),
    .load_data (load_data)
  );

  // Writes are gated by rst_n so a reset during SECOND leaves the second half untouched.
  always_comb begin
    mem_w_en       = 1'b0;
    mem_address    = req_addr[ADDR_W+1:2];
    mem_masking    = 4'b0000;
    mem_write_data = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          mem_masking    = be8[3:0];
          mem_write_data = wd64[31:0];
          mem_w_en       = wen_ok & rst_n;
        end
      end
      SECOND: begin
        mem_address    = waddr_q + ADDR_W'(1);
        mem_masking    = be8[7:4];
        mem_write_data = wd64[63:32];
        mem_w_en       = we_q & rst_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      off_q     <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      lo_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= wen_ok;
            funct3_q <= req_funct3;
            off_q    <= off;
            size_q   <= size;
            wdata_q  <= req_wdata;
            waddr_q  <= req_addr[ADDR_W+1:2];
            lo_q     <= mem_read_data;
            if (go_split) begin
              state <= SECOND;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= err;
              rsp_rdata <= (err | req_we) ? '0 : load_data;
            end
          end
        end
        SECOND: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= we_q ? '0 : load_data;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_split.sv
// Directed plus randomised bench for lsu_split with a byte-level reference memory.
module tb_lsu_split;
  import lsu_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_masking;
  logic [31:0]       mem_write_data, mem_read_data;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  lsu_split #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_w_en       (mem_w_en),
    .mem_address    (mem_address),
    .mem_masking    (mem_masking),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .state_dbg      (state_dbg)
  );

  // Data RAM driven by the DUT, plus an independent byte-addressed reference image.
  logic [31:0] ram  [0:255];
  logic [7:0]  gold [0:1023];

  assign mem_read_data = ram[mem_address];

  always @(posedge clk) begin
    if (mem_w_en) begin
      for (int l = 0; l < 4; l++)
        if (mem_masking[l]) ram[mem_address][8*l +: 8] <= mem_write_data[8*l +: 8];
    end
  end

  logic [32:0] exp_q[$];
  int          lat_q[$];
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [7:0]  a1;
    logic [3:0]  m1;
    logic [31:0] d1;
    logic        w1;
    logic [7:0]  a2;
    logic [3:0]  m2;
    logic [31:0] d2;
    logic        w2;
    logic [31:0] rd;
    logic        err;
    logic [7:0]  lat;
  } obs_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [2:0] f3, input logic [9:0] a,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                output int lat, output logic [7:0] be, output logic [63:0] w64);
    int         sz, off;
    logic       split;
    logic [7:0] b [4];
    off   = int'(a[1:0]);
    sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    split = (off + sz) > 4;
    err   = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4);
`ifdef MISALIGN_TRAP_EN
    if (split) err = 1'b1;
`endif
    be  = 8'(((1 << sz) - 1) << off);
    w64 = {32'b0, wd} << (8 * off);
    lat = (!err && split) ? 2 : 1;
    for (int i = 0; i < 4; i++) b[i] = gold[(int'(a) + i) % 1024];
    case (f3)
      3'd0:    rd = {{24{b[0][7]}}, b[0]};
      3'd1:    rd = {{16{b[1][7]}}, b[1], b[0]};
      3'd2:    rd = {b[3], b[2], b[1], b[0]};
      3'd4:    rd = {24'b0, b[0]};
      3'd5:    rd = {16'b0, b[1], b[0]};
      default: rd = '0;
    endcase
    if (err || we) rd = '0;
  endfunction

  // One request: drive, check both RAM access cycles, then pop and check the response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [9:0] a,
                        input logic [31:0] wd, output obs_t o);
    logic        err;
    logic [31:0] rd;
    int          elat, lat;
    logic [7:0]  be;
    logic [63:0] w64;
    logic [32:0] exp_rsp;
    int          exp_lat;
    logic [21:0] hi;
    model(we, f3, a, wd, err, rd, elat, be, w64);
    exp_q.push_back({err, rd});
    lat_q.push_back(elat);
    o = '0;
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    check("req_ready", req_ready, 1);
    hi         = 22'($urandom);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = {hi, a};
    req_wdata  = wd;
    #1;
    o.a1 = mem_address; o.m1 = mem_masking; o.d1 = mem_write_data; o.w1 = mem_w_en;
    check("acc_addr", o.a1, a[9:2]);
    check("acc_wen", o.w1, we && !err);
    if (!err) check("acc_mask", o.m1, be[3:0]);
    if (we && !err) check("acc_wdata", o.d1, w64[31:0]);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      o.a2 = mem_address; o.m2 = mem_masking; o.d2 = mem_write_data; o.w2 = mem_w_en;
      @(negedge clk);
      lat++;
    end
    o.lat = 8'(lat); o.rd = rsp_rdata; o.err = rsp_err;
    exp_rsp = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    check("rsp_valid", rsp_valid, 1);
    check("latency", lat, exp_lat);
    check("rsp_err", rsp_err, exp_rsp[32]);
    check("rsp_rdata", rsp_rdata, exp_rsp[31:0]);
    check("resp_wen", mem_w_en, 0);
    check("resp_mask", mem_masking, 0);
    if (exp_lat == 2 && lat == 2) begin
      check("sec_addr", o.a2, 8'(a[9:2] + 8'd1));
      check("sec_wen", o.w2, we);
      check("sec_mask", o.m2, be[7:4]);
      if (we) check("sec_wdata", o.d2, w64[63:32]);
    end
    if (we && !err)
      for (int i = 0; i < 8; i++)
        if (be[i]) gold[(int'(a) + i - int'(a[1:0])) % 1024 + 0] = w64[8*i +: 8];
    @(negedge clk);
    check("rsp_pulse", rsp_valid, 0);
  endtask

  initial begin
    obs_t       o;
    logic [2:0] f3_tab [10];
    logic [9:0] ra;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    for (int i = 0; i < 256; i++) ram[i] = '0;
    for (int i = 0; i < 1024; i++) gold[i] = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_state", state_dbg, IDLE);
    check("rst_wen", mem_w_en, 0);
    check("rst_mask", mem_masking, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", req_ready, 1);

    // Aligned word store.
    do_req(1'b1, F3_W, 10'h010, 32'hDEADBEEF, o);
    check("sw_addr", o.a1, 8'd4);
    check("sw_mask", o.m1, 4'b1111);
    check("sw_wen", o.w1, 1);
    check("sw_lat", o.lat, 1);

    // Byte store to the top lane, then signed and unsigned byte loads.
    do_req(1'b1, F3_B, 10'h013, 32'h000000A5, o);
    check("sb_mask", o.m1, 4'b1000);
    check("sb_data", o.d1[31:24], 8'hA5);
    do_req(1'b0, F3_B, 10'h013, 32'h0, o);
    check("lb_val", o.rd, 32'hFFFFFFA5);
    do_req(1'b0, F3_BU, 10'h013, 32'h0, o);
    check("lbu_val", o.rd, 32'h000000A5);

    // Misaligned word store and reload.
    do_req(1'b1, F3_W, 10'h00E, 32'h11223344, o);
    check("split_a1", o.a1, 8'd3);
`ifndef MISALIGN_TRAP_EN
    check("split_m1", o.m1, 4'b1100);
    check("split_d1", o.d1[31:16], 16'h3344);
    check("split_a2", o.a2, 8'd4);
    check("split_m2", o.m2, 4'b0011);
    check("split_d2", o.d2[15:0], 16'h1122);
    do_req(1'b0, F3_W, 10'h00E, 32'h0, o);
    check("lw_split_val", o.rd, 32'h11223344);
    check("lw_split_lat", o.lat, 2);
`else
    check("trap_sw_wen", o.w1, 0);
    check("trap_sw_err", o.err, 1);
`endif

    // Split load wrapping from word 255 to word 0.
    do_req(1'b1, F3_B, 10'h3FF, 32'h00000022, o);
    check("wrap_sb_addr", o.a1, 8'd255);
    do_req(1'b1, F3_B, 10'h000, 32'h00000091, o);
    do_req(1'b0, F3_H, 10'h3FF, 32'h0, o);
`ifndef MISALIGN_TRAP_EN
    check("wrap_a2", o.a2, 8'd0);
    check("wrap_val", o.rd, 32'hFFFF9122);
`else
    check("wrap_trap_err", o.err, 1);
`endif

    // Illegal operations.
    do_req(1'b1, 3'd3, 10'h020, 32'hFFFFFFFF, o);
    check("ill3_err", o.err, 1);
    check("ill3_wen", o.w1, 0);
    do_req(1'b1, F3_BU, 10'h020, 32'hFFFFFFFF, o);
    check("ill_sbu_err", o.err, 1);
    do_req(1'b0, 3'd6, 10'h020, 32'h0, o);
    do_req(1'b0, F3_W, 10'h020, 32'h0, o);
    check("ill_nowrite", o.rd, 32'h0);
    do_req(1'b0, F3_W, 10'h002, 32'h0, o);
`ifdef MISALIGN_TRAP_EN
    check("trap_lw_err", o.err, 1);
    check("trap_lw_lat", o.lat, 1);
`else
    check("lw02_lat", o.lat, 2);
`endif

`ifndef MISALIGN_TRAP_EN
    // Reset while in SECOND of a split store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h00000026; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rs_state_second", state_dbg, SECOND);
    check("rs_addr2", mem_address, 8'd10);
    rst_n = 1'b0;
    #1;
    check("rs_wen_gated", mem_w_en, 0);
    @(negedge clk);
    check("rs_state_idle", state_dbg, IDLE);
    check("rs_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    gold[10'h026] = 8'h0D;
    gold[10'h027] = 8'hF0;
    @(negedge clk);
    check("rs_no_rsp2", rsp_valid, 0);
    check("rs_ram_hi", ram[10], 32'h0);
    check("rs_ram_lo", ram[9][31:16], 16'hF00D);
    do_req(1'b0, F3_H, 10'h026, 32'h0, o);
    check("rs_lh_val", o.rd, 32'hFFFFF00D);
    do_req(1'b0, F3_W, 10'h028, 32'h0, o);
    check("rs_lw_val", o.rd, 32'h0);
`endif

    // Randomised mix against the reference image.
    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 10'(10'h3FC + $urandom_range(0, 3))
                                        : 10'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 9)], ra, $urandom, o);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
